usb_dac_stream_sink: RTL and testbench

- Downstream consumer of the FX3 slave-FIFO read controller.
- Captures words from the FX3 data bus whenever the controller asserts SLRD/SLOE, compensating for the bus read latency, and buffers them in a synchronous FIFO.
- Paces samples out to the DA converter at a programmable rate, with prime, underflow and overflow handling.
- Single clock domain; the clock is shared with the read controller.

---
 rtl/usb_dac_stream_sink.sv | 128 ++++++++++++
 tb/tb_usb_dac_stream_sink.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_dac_stream_sink.sv
// FX3 read-data sink: latency-compensated capture into a FIFO, paced out to a DAC.
// Build option DAC_OFFSET_BIN_EN: invert the sample MSB (two's complement -> offset binary).
//
// state | meaning
// IDLE  | pacing off, divider held at 0
// PRIME | divider running, waiting for FIFO to reach PRIME_LVL, no pops
// RUN   | one pop per divider tick, underflow flagged on empty
module usb_dac_stream_sink #(
   parameter int DATA_W    = 16,
   parameter int DAC_W     = 14,
   parameter int FIFO_AW   = 9,
   parameter int RD_LAT    = 2,
   parameter int PRIME_LVL = 256,
   parameter int AF_MARGIN = 16,
   parameter int DIV_W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  usb_data,
   input  logic               SLRD,
   input  logic               SLOE,
   input  logic               dac_en,
   input  logic [DIV_W-1:0]   dac_div,
   input  logic               clr_flags,
   output logic [DAC_W-1:0]   dac_data,
   output logic               dac_wr,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               almost_full,
   output logic               overflow,
   output logic               underflow
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] AF_THR    = (FIFO_AW+1)'(DEPTH - AF_MARGIN);
   localparam logic [FIFO_AW:0] PRIME_THR = (FIFO_AW+1)'(PRIME_LVL);
   localparam logic [DAC_W-1:0] MSB_MASK  = {1'b1, {(DAC_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t             state, state_nxt;
   logic [RD_LAT-1:0]  rd_pipe;
   logic [DAC_W-1:0]   mem [DEPTH];
   logic [FIFO_AW:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt, level_nxt;
   logic [DIV_W-1:0]   div_cnt;
   logic               rd_hit, push, full, empty, tick, pop, push_ok, ovf_evt, unf_evt;
   logic [DAC_W-1:0]   cap_sample, out_sample;

   generate
      if (DATA_W > DAC_W) begin : g_low_bits
         logic unused_low;
         assign unused_low = ^usb_data[DATA_W-DAC_W-1:0];
      end
   endgenerate

   assign rd_hit     = ~SLRD & ~SLOE;
   assign push       = rd_pipe[RD_LAT-1];
   assign cap_sample = usb_data[DATA_W-1 -: DAC_W];

   assign fifo_level = wr_ptr - rd_ptr;
   assign full       = fifo_level[FIFO_AW];
   assign empty      = (fifo_level == '0);

   assign tick    = (state != IDLE) && (div_cnt == dac_div);
   assign pop     = (state == RUN) && tick && !empty;
   // a full FIFO still takes a word when a pop frees the slot in the same cycle
   assign push_ok = push && (!full || pop);
   assign ovf_evt = push && !push_ok;
   assign unf_evt = (state == RUN) && tick && empty;

   assign wr_nxt    = wr_ptr + (FIFO_AW+1)'(push_ok);
   assign rd_nxt    = rd_ptr + (FIFO_AW+1)'(pop);
   assign level_nxt = wr_nxt - rd_nxt;

`ifdef DAC_OFFSET_BIN_EN
   assign out_sample = mem[rd_ptr[FIFO_AW-1:0]] ^ MSB_MASK;
`else
   assign out_sample = mem[rd_ptr[FIFO_AW-1:0]];
   logic unused_mask;
   assign unused_mask = ^MSB_MASK;
`endif

   always_ff @(posedge clk) begin
      if (!rst && push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= cap_sample;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pipe     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         div_cnt     <= '0;
         dac_data    <= '0;
         dac_wr      <= 1'b0;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         rd_pipe[0] <= rd_hit;
         for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         if (state == IDLE || tick) div_cnt <= '0;
         else                       div_cnt <= div_cnt + DIV_W'(1);
         dac_wr <= pop;
         if (pop) dac_data <= out_sample;
         almost_full <= (level_nxt >= AF_THR);
         overflow    <= ovf_evt | (overflow  & ~clr_flags);
         underflow   <= unf_evt | (underflow & ~clr_flags);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (dac_en) state_nxt = PRIME;
         PRIME:   if (!dac_en) state_nxt = IDLE;
                  else if (fifo_level >= PRIME_THR) state_nxt = RUN;
         RUN:     if (!dac_en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_usb_dac_stream_sink.sv
// Bench for usb_dac_stream_sink: directed steps plus random traffic against a queue-based model.
// Honours DAC_OFFSET_BIN_EN when defined for the build.
module tb_usb_dac_stream_sink;
   localparam int RD_LAT = 2;
   localparam int DEPTH  = 512;
   localparam int AF_LVL = 496;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] usb_data = '0;
   logic        SLRD = 1'b1, SLOE = 1'b1, dac_en = 1'b0, clr_flags = 1'b0;
   logic [7:0]  dac_div = '0;
   logic [13:0] dac_data;
   logic        dac_wr, almost_full, overflow, underflow;
   logic [9:0]  fifo_level;

   int total = 0;
   int bad   = 0;

   usb_dac_stream_sink #(.PRIME_LVL(4)) dut (
      .clk(clk), .rst(rst), .usb_data(usb_data), .SLRD(SLRD), .SLOE(SLOE),
      .dac_en(dac_en), .dac_div(dac_div), .clr_flags(clr_flags),
      .dac_data(dac_data), .dac_wr(dac_wr), .fifo_level(fifo_level),
      .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // reference model: queue of words, pending-read queue, mode 0=idle 1=prime 2=run
   logic [15:0] q[$];
   bit          hits[$];
   int          m_cnt, m_mode;
   logic [13:0] m_data;
   bit          m_wr, m_ovf, m_unf;

   function automatic logic [13:0] smp(input logic [15:0] w);
      logic [13:0] s;
      s = w[15:2];
`ifdef DAC_OFFSET_BIN_EN
      s = s ^ 14'h2000;
`endif
      return s;
   endfunction

   task automatic model_edge();
      bit push, tick, popv, ovf_e, unf_e;
      int lvl;
      if (rst) begin
         q.delete(); hits.delete();
         for (int i = 0; i < RD_LAT; i++) hits.push_back(1'b0);
         m_cnt = 0; m_mode = 0; m_data = '0; m_wr = 0; m_ovf = 0; m_unf = 0;
         return;
      end
      lvl  = q.size();
      push = hits.pop_front();
      hits.push_back(!SLRD && !SLOE);
      tick  = (m_mode != 0) && (m_cnt == int'(dac_div));
      popv  = (m_mode == 2) && tick && (lvl > 0);
      unf_e = (m_mode == 2) && tick && (lvl == 0);
      ovf_e = push && (lvl == DEPTH) && !popv;
      m_wr  = popv;
      if (popv) m_data = smp(q.pop_front());
      if (push && !ovf_e) q.push_back(usb_data);
      m_ovf = ovf_e || (m_ovf && !clr_flags);
      m_unf = unf_e || (m_unf && !clr_flags);
      if (m_mode == 0 || tick) m_cnt = 0;
      else                     m_cnt = (m_cnt + 1) % 256;
      case (m_mode)
         0: if (dac_en) m_mode = 1;
         1: if (!dac_en) m_mode = 0; else if (lvl >= 4) m_mode = 2;
         default: if (!dac_en) m_mode = 0;
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("dac_data",    32'(dac_data),    32'(m_data));
      chk("dac_wr",      32'(dac_wr),      32'(m_wr));
      chk("fifo_level",  32'(fifo_level),  32'(q.size()));
      chk("almost_full", 32'(almost_full), 32'(q.size() >= AF_LVL));
      chk("overflow",    32'(overflow),    32'(m_ovf));
      chk("underflow",   32'(underflow),   32'(m_unf));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] pw[4];
      logic [15:0] cv[4];
      logic [13:0] seen[2];
      int n, last;

      // reset state
      rst = 1'b1;
      repeat (3) step();
      chk("rst_level", 32'(fifo_level), 0);
      chk("rst_wr", 32'(dac_wr), 0);
      rst = 1'b0;

      // capture latency and order
      for (int k = 0; k < 6; k++) begin
         usb_data = 16'(16'h1000 * (k + 1));
         SLRD = (k < 4) ? 1'b0 : 1'b1;
         SLOE = SLRD;
         step();
      end
      step();
      chk("cap_level", 32'(fifo_level), 4);

      // prime and pace at dac_div=3
      pw[0] = 16'h3000; pw[1] = 16'h4000; pw[2] = 16'h5000; pw[3] = 16'h6000;
      dac_div = 8'd3; dac_en = 1'b1;
      n = 0; last = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         step();
         if (dac_wr) begin
            if (n > 0) chk("pace_gap", 32'(c - last), 4);
            chk("pace_data", 32'(dac_data), 32'(smp(pw[n])));
            last = c;
            n++;
         end
      end
      chk("pace_count", 32'(n), 4);
      chk("pace_unf", 32'(underflow), 0);

      // underflow with a single word at dac_div=0
      dac_div = 8'd0;
      repeat (3) step();
      chk("unf_empty", 32'(underflow), 1);
      usb_data = 16'h0000; SLRD = 1'b0; SLOE = 1'b0;
      step();
      SLRD = 1'b1; SLOE = 1'b1;
      step();
      usb_data = 16'hABCC;
      step();
      clr_flags = 1'b1;
      step();
      chk("unf_pop_wr", 32'(dac_wr), 1);
      chk("unf_pop_data", 32'(dac_data), 32'(smp(16'hABCC)));
      chk("unf_cleared", 32'(underflow), 0);
      clr_flags = 1'b0;
      step();
      chk("unf_again_wr", 32'(dac_wr), 0);
      chk("unf_again", 32'(underflow), 1);
      chk("unf_hold", 32'(dac_data), 32'(smp(16'hABCC)));
      dac_en = 1'b0;
      step();
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      chk("unf_clr", 32'(underflow), 0);

      // random traffic
      for (int k = 0; k < 1500; k++) begin
         bit hit;
         rst = ($urandom_range(0, 499) == 0);
         hit = ($urandom_range(0, 9) < 6);
         SLRD = hit ? 1'b0 : 1'($urandom_range(0, 1));
         SLOE = hit ? 1'b0 : 1'b1;
         usb_data = 16'($urandom);
         if ($urandom_range(0, 49) == 0) dac_en = ~dac_en;
         if ($urandom_range(0, 49) == 0) dac_div = 8'($urandom_range(0, 3));
         clr_flags = ($urandom_range(0, 19) == 0);
         step();
      end
      rst = 1'b0; clr_flags = 1'b0; dac_en = 1'b0; SLRD = 1'b1; SLOE = 1'b1;

      // overflow and full boundary
      rst = 1'b1;
      step();
      rst = 1'b0;
      SLRD = 1'b0; SLOE = 1'b0;
      for (int k = 0; k < 520; k++) begin
         usb_data = 16'($urandom);
         step();
         if (k == 496) chk("af_at_495", 32'(almost_full), 0);
         if (k == 497) chk("af_at_496", 32'(almost_full), 1);
      end
      chk("ovf_set", 32'(overflow), 1);
      chk("full_level", 32'(fifo_level), DEPTH);
      chk("full_af", 32'(almost_full), 1);
      dac_en = 1'b1; dac_div = 8'd0;
      repeat (5) step();
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      chk("full_pushpop_level", 32'(fifo_level), DEPTH);
      chk("full_pushpop_ovf", 32'(overflow), 0);
      chk("full_pushpop_wr", 32'(dac_wr), 1);

      // reset mid-burst with reads in flight
      rst = 1'b1; dac_en = 1'b0;
      step();
      rst = 1'b0; SLRD = 1'b1; SLOE = 1'b1;
      chk("mrst_level", 32'(fifo_level), 0);
      chk("mrst_data", 32'(dac_data), 0);
      chk("mrst_ovf", 32'(overflow), 0);
      chk("mrst_af", 32'(almost_full), 0);
      repeat (4) step();
      chk("mrst_no_push", 32'(fifo_level), 0);

      // sample coding
      cv[0] = 16'h0000; cv[1] = 16'hFFFC; cv[2] = 16'h1234; cv[3] = 16'h5678;
      for (int k = 0; k < 6; k++) begin
         SLRD = (k < 4) ? 1'b0 : 1'b1;
         SLOE = SLRD;
         usb_data = (k >= 2) ? cv[k-2] : 16'h0000;
         step();
      end
      dac_en = 1'b1; dac_div = 8'd0;
      n = 0;
      for (int c = 0; c < 20 && n < 2; c++) begin
         step();
         if (dac_wr) begin
            seen[n] = dac_data;
            n++;
         end
      end
      chk("conv_count", 32'(n), 2);
`ifdef DAC_OFFSET_BIN_EN
      chk("conv_zero", 32'(seen[0]), 32'h2000);
      chk("conv_fffc", 32'(seen[1]), 32'h1FFF);
`else
      chk("conv_zero", 32'(seen[0]), 32'h0000);
      chk("conv_fffc", 32'(seen[1]), 32'h3FFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
